// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline control slice.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int REG_IDX_W        = 4;
  localparam int MEM_WAIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DONE = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wait_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_fsm
// Description : Data-memory wait sequencer; stalls an access for MEM_WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_fsm
  import pipe_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEFAULT,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic mw,
  output logic mem_busy
);

  localparam logic             C_WAIT_EN   = (MEM_WAIT > 0);
  localparam logic             C_SKIP_WAIT = (MEM_WAIT == 1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD  = CNT_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  mem_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= M_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt holds stall cycles still owed, the current WAIT cycle included;
  // the IDLE request cycle is the first stall cycle, so WAIT lasts MEM_WAIT-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      M_IDLE: begin
        if (mem_req && C_WAIT_EN) begin
          w_cnt_nxt   = C_CNT_LOAD;
          w_state_nxt = C_SKIP_WAIT ? M_DONE : M_WAIT;
        end
      end
      M_WAIT: begin
        if (r_cnt <= C_CNT_ONE) begin
          w_state_nxt = M_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      M_DONE: w_state_nxt = M_IDLE;
      default: begin
        w_state_nxt = M_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign mw       = ((r_state == M_IDLE) && mem_req && C_WAIT_EN) || (r_state == M_WAIT);
  assign mem_busy = (r_state == M_WAIT);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Freeze/flush sequencing for data hazards, branches and memory waits.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEFAULT,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fwd_en,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_src1_vld,
  input  logic                 id_two_src,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 mem_wb_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 exe_b_taken,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic                 perf_clr,
  output logic                 if_freeze,
  output logic                 if_id_freeze,
  output logic                 if_id_flush,
  output logic                 id_exe_flush,
  output logic                 back_freeze,
  output logic                 mem_busy,
  output logic [PERF_W-1:0]    stall_cycles
);

  localparam logic [PERF_W-1:0] C_PERF_MAX = '1;

  logic w_mw, w_fsm_busy;
  logic w_m1, w_m2, w_n1, w_n2, w_hz;
  logic [PERF_W-1:0] r_stall_cycles;

  mem_wait_fsm #(
    .MEM_WAIT (MEM_WAIT),
    .CNT_W    (CNT_W)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_r_en | mem_w_en),
    .mw       (w_mw),
    .mem_busy (w_fsm_busy)
  );

  assign w_m1 = exe_wb_en && (exe_dest == id_src1);
  assign w_m2 = id_two_src && exe_wb_en && (exe_dest == id_src2);
  assign w_n1 = mem_wb_en && (mem_dest == id_src1);
  assign w_n2 = id_two_src && mem_wb_en && (mem_dest == id_src2);

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign w_hz = fwd_en ? (exe_mem_r_en && ((id_src1_vld && w_m1) || w_m2))
                       : ((id_src1_vld && (w_m1 || w_n1)) || w_m2 || w_n2);

  always_comb begin
    if_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    back_freeze  = 1'b0;
    mem_busy     = 1'b0;
    if (rst) begin
      mem_busy = w_fsm_busy;
      if (w_mw) begin
        if_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        back_freeze  = 1'b1;
      end else if (exe_b_taken) begin
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (w_hz) begin
        if_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_exe_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
    end else if (if_freeze && (r_stall_cycles != C_PERF_MAX)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
